// File: rtl/calc_pkg.sv
// Shared constants for the calculator key-entry slice: key codes, operator
// codes, entry-state encoding and the default operand width in digits.
package calc_pkg;

    localparam int DEFAULT_MAX_DIGITS = 4;

    localparam logic [7:0] KEY_DIGIT_0 = 8'h30;
    localparam logic [7:0] KEY_DIGIT_9 = 8'h39;
    localparam logic [7:0] KEY_ADD     = 8'h61;
    localparam logic [7:0] KEY_SUB     = 8'h62;
    localparam logic [7:0] KEY_MUL     = 8'h63;
    localparam logic [7:0] KEY_DIV     = 8'h64;
    localparam logic [7:0] KEY_EQ      = 8'h65;
    localparam logic [7:0] KEY_CLR     = 8'h66;

    typedef enum logic [1:0] {
        S_NUM1 = 2'd0,
        S_NUM2 = 2'd1,
        S_HOLD = 2'd2
    } entry_state_t;

endpackage

// File: rtl/key_classify.sv
// Combinational decode of an ASCII key code into digit / operator / equals /
// clear / unrecognised classes. Exactly one class flag is high for any code.
module key_classify
    import calc_pkg::*;
(
    input  logic [7:0] key_code,
    output logic       is_digit,
    output logic [3:0] digit,
    output logic       is_op,
    output logic       is_eq,
    output logic       is_clr,
    output logic       is_bad
);

    always_comb begin
        is_digit = 1'b0;
        digit    = '0;
        is_op    = 1'b0;
        is_eq    = 1'b0;
        is_clr   = 1'b0;
        is_bad   = 1'b0;
        if (key_code >= KEY_DIGIT_0 && key_code <= KEY_DIGIT_9) begin
            is_digit = 1'b1;
            digit    = key_code[3:0];
        end else if (key_code >= KEY_ADD && key_code <= KEY_DIV) begin
            is_op = 1'b1;
        end else if (key_code == KEY_EQ) begin
            is_eq = 1'b1;
        end else if (key_code == KEY_CLR) begin
            is_clr = 1'b1;
        end else begin
            is_bad = 1'b1;
        end
    end

endmodule

// File: rtl/key_entry.sv
// Calculator key-entry front end: assembles two packed-BCD operands and an
// operator from a key stream, pulsing calc_go on '=' or err on a rejected key.
module key_entry
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = DEFAULT_MAX_DIGITS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    key_valid,
    input  logic [7:0]              key_code,
    output logic [4*MAX_DIGITS-1:0] reg_num1,
    output logic [4*MAX_DIGITS-1:0] reg_num2,
    output logic [2:0]              cnt1,
    output logic [2:0]              cnt2,
    output logic [7:0]              sym,
    output logic                    calc_go,
    output logic                    err,
    output logic [1:0]              state
);

    localparam int         NUM_W   = 4 * MAX_DIGITS;
    localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

    logic             is_digit, is_op, is_eq, is_clr, is_bad;
    logic [3:0]       digit;

    entry_state_t     state_q, state_n;
    logic [NUM_W-1:0] num1_q, num1_n, num2_q, num2_n;
    logic [2:0]       cnt1_q, cnt1_n, cnt2_q, cnt2_n;
    logic [7:0]       sym_q, sym_n;
    logic             go_q, go_n, err_q, err_n;

    key_classify u_classify (
        .key_code (key_code),
        .is_digit (is_digit),
        .digit    (digit),
        .is_op    (is_op),
        .is_eq    (is_eq),
        .is_clr   (is_clr),
        .is_bad   (is_bad)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_NUM1;
            num1_q  <= '0;
            num2_q  <= '0;
            cnt1_q  <= '0;
            cnt2_q  <= '0;
            sym_q   <= '0;
            go_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            num1_q  <= num1_n;
            num2_q  <= num2_n;
            cnt1_q  <= cnt1_n;
            cnt2_q  <= cnt2_n;
            sym_q   <= sym_n;
            go_q    <= go_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n = state_q;
        num1_n  = num1_q;
        num2_n  = num2_q;
        cnt1_n  = cnt1_q;
        cnt2_n  = cnt2_q;
        sym_n   = sym_q;
        go_n    = 1'b0;
        err_n   = 1'b0;
        if (key_valid) begin
            if (is_clr) begin
                state_n = S_NUM1;
                num1_n  = '0;
                num2_n  = '0;
                cnt1_n  = '0;
                cnt2_n  = '0;
                sym_n   = '0;
            end else if (is_bad) begin
                err_n = 1'b1;
            end else begin
                unique case (state_q)
                    S_NUM1: begin
                        if (is_digit && cnt1_q < MAX_CNT) begin
                            num1_n = (num1_q << 4) | NUM_W'(digit);
                            cnt1_n = cnt1_q + 3'd1;
                        end else if (is_op && cnt1_q != '0) begin
                            sym_n   = key_code;
                            state_n = S_NUM2;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                    S_NUM2: begin
                        if (is_digit && cnt2_q < MAX_CNT) begin
                            num2_n = (num2_q << 4) | NUM_W'(digit);
                            cnt2_n = cnt2_q + 3'd1;
                        end else if (is_op && cnt2_q == '0) begin
                            sym_n = key_code;
                        end else if (is_eq && cnt2_q != '0) begin
                            go_n    = 1'b1;
                            state_n = S_HOLD;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                    S_HOLD: begin
                        // A new digit starts a fresh calculation from scratch
                        if (is_digit) begin
                            state_n = S_NUM1;
                            num1_n  = NUM_W'(digit);
                            num2_n  = '0;
                            cnt1_n  = 3'd1;
                            cnt2_n  = '0;
                            sym_n   = '0;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                    default: state_n = S_NUM1;
                endcase
            end
        end
    end

    assign reg_num1 = num1_q;
    assign reg_num2 = num2_q;
    assign cnt1     = cnt1_q;
    assign cnt2     = cnt2_q;
    assign sym      = sym_q;
    assign calc_go  = go_q;
    assign err      = err_q;
    assign state    = state_q;

endmodule
